mem_arbiter: RTL and testbench

- Shares the single-ported unified RAM between the instruction-side requester (icache) and the data-side requester (dcache).
- Sits between the caches block and the RAM model.
- Grants one requester at a time and holds the grant until the RAM completes the access.
- Returns the per-requester wait/load signals the caches consume.

---
 rtl/arb_types_pkg.sv | 24 ++
 rtl/mem_arb_pick.sv | 29 ++
 rtl/mem_arbiter.sv | 126 ++++++++++++
 tb/tb_mem_arbiter.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/arb_types_pkg.sv
// Shared types for the unified-RAM arbiter: RAM status codes, arbiter states
// and the word/address widths.
package arb_types_pkg;

   localparam int ARB_WORD_W = 32;
   localparam int ARB_ADDR_W = 32;

   typedef logic [ARB_WORD_W-1:0] word_t;
   typedef logic [ARB_ADDR_W-1:0] addr_t;

   typedef enum logic [1:0] {
      FREE   = 2'd0,
      BUSY   = 2'd1,
      ACCESS = 2'd2,
      ERROR  = 2'd3
   } ramstate_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      IGNT = 2'd1,
      DGNT = 2'd2
   } arb_state_t;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational grant picker for the idle state. With MEM_ARB_RR_EN defined a
// data/instruction tie alternates on the previous tie winner; otherwise data wins.
module mem_arb_pick
   import arb_types_pkg::*;
(
   input  logic       d_req,
   input  logic       i_req,
`ifdef MEM_ARB_RR_EN
   input  logic       last_grant,   // 1 = data won the previous tie
`endif
   output arb_state_t grant
);

   always_comb begin
      grant = IDLE;
      if (d_req && i_req) begin
`ifdef MEM_ARB_RR_EN
         grant = last_grant ? IGNT : DGNT;
`else
         grant = DGNT;
`endif
      end else if (d_req) begin
         grant = DGNT;
      end else if (i_req) begin
         grant = IGNT;
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter sharing the single-ported unified RAM between icache and dcache.
// Optional round-robin tie-break enabled by defining MEM_ARB_RR_EN.
module mem_arbiter
   import arb_types_pkg::*;
#(
   parameter int WORD_W = ARB_WORD_W,
   parameter int ADDR_W = ARB_ADDR_W
) (
   input  logic              CLK,
   input  logic              nRST,
   input  logic              iREN,
   input  logic [ADDR_W-1:0] iaddr,
   output logic              iwait,
   output logic [WORD_W-1:0] iload,
   input  logic              dREN,
   input  logic              dWEN,
   input  logic [ADDR_W-1:0] daddr,
   input  logic [WORD_W-1:0] dstore,
   output logic              dwait,
   output logic [WORD_W-1:0] dload,
   output logic              ramREN,
   output logic              ramWEN,
   output logic [ADDR_W-1:0] ramaddr,
   output logic [WORD_W-1:0] ramstore,
   input  logic [WORD_W-1:0] ramload,
   input  logic [1:0]        ramstate,
   output logic              arb_err
);

   ramstate_t  ram_st;
   arb_state_t state_q, state_d, pick_grant;
   logic       arb_err_q, arb_err_d;
   logic       d_req, i_req, granted_live;

   assign ram_st = ramstate_t'(ramstate);
   assign d_req  = dREN | dWEN;
   assign i_req  = iREN;

`ifdef MEM_ARB_RR_EN
   logic last_grant_q, last_grant_d;

   mem_arb_pick u_pick (
      .d_req      (d_req),
      .i_req      (i_req),
      .last_grant (last_grant_q),
      .grant      (pick_grant)
   );

   // Only a tie updates the history, so consecutive ties alternate.
   always_comb begin
      last_grant_d = last_grant_q;
      if (state_q == IDLE && d_req && i_req)
         last_grant_d = (pick_grant == DGNT);
   end
`else
   mem_arb_pick u_pick (
      .d_req (d_req),
      .i_req (i_req),
      .grant (pick_grant)
   );
`endif

   always_comb begin
      state_d      = state_q;
      arb_err_d    = arb_err_q;
      granted_live = (state_q == DGNT) ? d_req : i_req;
      unique case (state_q)
         IDLE: state_d = pick_grant;
         IGNT, DGNT: begin
            if (ram_st == ERROR)
               arb_err_d = 1'b1;
            if (ram_st == ACCESS || ram_st == ERROR || !granted_live)
               state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (!nRST) begin
         state_q   <= IDLE;
         arb_err_q <= 1'b0;
`ifdef MEM_ARB_RR_EN
         last_grant_q <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         arb_err_q <= arb_err_d;
`ifdef MEM_ARB_RR_EN
         last_grant_q <= last_grant_d;
`endif
      end
   end

   // RAM side follows the live request inputs so a withdrawal drops enables at once.
   always_comb begin
      ramREN   = 1'b0;
      ramWEN   = 1'b0;
      ramaddr  = '0;
      ramstore = '0;
      iwait    = 1'b1;
      dwait    = 1'b1;
      iload    = '0;
      dload    = '0;
      unique case (state_q)
         DGNT: begin
            ramaddr  = daddr;
            ramstore = dstore;
            ramWEN   = dWEN;
            ramREN   = dREN & ~dWEN;
            dwait    = (ram_st != ACCESS);
            dload    = ramload;
         end
         IGNT: begin
            ramREN  = iREN;
            ramaddr = iaddr;
            iwait   = (ram_st != ACCESS);
            iload   = ramload;
         end
         default: ;
      endcase
   end

   assign arb_err = arb_err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios with literal
// expectations plus randomized traffic checked every cycle against a model.
module tb_mem_arbiter;

   logic        clk = 1'b0;
   logic        nRST;
   logic        iREN, dREN, dWEN;
   logic [31:0] iaddr, daddr, dstore, ramload;
   logic [1:0]  ramstate;
   logic        iwait, dwait, ramREN, ramWEN, arb_err;
   logic [31:0] iload, dload, ramaddr, ramstore;

   int checks   = 0;
   int failures = 0;
   bit chk_en   = 0;

   // model state: owner 0 = none, 1 = instruction, 2 = data
   int m_owner = 0;
   bit m_err   = 0;
   bit m_last  = 0;

   always #5 clk = ~clk;

   mem_arbiter dut (
      .CLK      (clk),
      .nRST     (nRST),
      .iREN     (iREN),
      .iaddr    (iaddr),
      .iwait    (iwait),
      .iload    (iload),
      .dREN     (dREN),
      .dWEN     (dWEN),
      .daddr    (daddr),
      .dstore   (dstore),
      .dwait    (dwait),
      .dload    (dload),
      .ramREN   (ramREN),
      .ramWEN   (ramWEN),
      .ramaddr  (ramaddr),
      .ramstore (ramstore),
      .ramload  (ramload),
      .ramstate (ramstate),
      .arb_err  (arb_err)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Per-cycle comparison against the behavioural model.
   initial begin
      int          owner_nxt;
      bit          err_nxt, last_nxt, d_req, live;
      logic [31:0] e_addr, e_store, e_il, e_dl;
      logic        e_ren, e_wen, e_iw, e_dw;
      owner_nxt = 0;
      err_nxt   = 0;
      last_nxt  = 0;
      forever begin
         @(negedge clk);
         if (chk_en) begin
            e_ren = 0; e_wen = 0; e_addr = 0; e_store = 0;
            e_iw = 1; e_dw = 1; e_il = 0; e_dl = 0;
            if (m_owner == 2) begin
               e_addr  = daddr;
               e_store = dstore;
               e_wen   = dWEN;
               e_ren   = dREN && !dWEN;
               e_dw    = (ramstate != 2'd2);
               e_dl    = ramload;
            end else if (m_owner == 1) begin
               e_ren  = iREN;
               e_addr = iaddr;
               e_iw   = (ramstate != 2'd2);
               e_il   = ramload;
            end
            check("m_ramREN", ramREN, e_ren);
            check("m_ramWEN", ramWEN, e_wen);
            check("m_ramaddr", ramaddr, e_addr);
            check("m_ramstore", ramstore, e_store);
            check("m_iwait", iwait, e_iw);
            check("m_dwait", dwait, e_dw);
            check("m_iload", iload, e_il);
            check("m_dload", dload, e_dl);
            check("m_arb_err", arb_err, m_err);

            d_req     = dREN || dWEN;
            owner_nxt = m_owner;
            err_nxt   = m_err;
            last_nxt  = m_last;
            if (!nRST) begin
               owner_nxt = 0;
               err_nxt   = 0;
               last_nxt  = 0;
            end else if (m_owner == 0) begin
               if (d_req && iREN) begin
`ifdef MEM_ARB_RR_EN
                  owner_nxt = m_last ? 1 : 2;
                  last_nxt  = (owner_nxt == 2);
`else
                  owner_nxt = 2;
`endif
               end else if (d_req) owner_nxt = 2;
               else if (iREN) owner_nxt = 1;
            end else begin
               live = (m_owner == 2) ? d_req : iREN;
               if (ramstate == 2'd3) err_nxt = 1;
               if (ramstate == 2'd2 || ramstate == 2'd3 || !live) owner_nxt = 0;
            end
         end
         @(posedge clk);
         if (chk_en) begin
            m_owner = owner_nxt;
            m_err   = err_nxt;
            m_last  = last_nxt;
         end
      end
   end

   // Complete all outstanding requests with ACCESS responses.
   task automatic drain();
      bit di, dd;
      ramstate = 2'd2;
      for (int k = 0; k < 10; k++) begin
         #1;
         di = !iwait;
         dd = !dwait;
         tick();
         if (di) iREN = 0;
         if (dd) begin dREN = 0; dWEN = 0; end
         if (!iREN && !dREN && !dWEN) break;
      end
      check("drain_done", {29'd0, iREN, dREN, dWEN}, 32'd0);
      ramstate = 2'd0;
   endtask

   initial begin
      logic [31:0] exp_tie2;
      bit idone, ddone;
      int r;
      nRST = 0; iREN = 0; dREN = 0; dWEN = 0;
      iaddr = 0; daddr = 0; dstore = 0; ramload = 0; ramstate = 2'd0;
      repeat (2) tick();
      chk_en = 1;
      check("rst_ramREN", ramREN, 0);
      check("rst_ramWEN", ramWEN, 0);
      check("rst_ramaddr", ramaddr, 0);
      check("rst_ramstore", ramstore, 0);
      check("rst_iwait", iwait, 1);
      check("rst_dwait", dwait, 1);
      check("rst_arb_err", arb_err, 0);
      nRST = 1;
      tick();

      // instruction read with two BUSY cycles
      iREN = 1; iaddr = 32'h40;
      #1 check("i_lat0_ramREN", ramREN, 0);
      tick(); ramstate = 2'd1;
      #1 check("i_ramREN", ramREN, 1);
      check("i_ramaddr", ramaddr, 32'h40);
      check("i_busy_iwait", iwait, 1);
      tick();
      tick(); ramstate = 2'd2; ramload = 32'hDEADBEEF;
      #1 check("i_acc_iwait", iwait, 0);
      check("i_acc_iload", iload, 32'hDEADBEEF);
      tick(); iREN = 0; ramstate = 2'd0;
      #1 check("i_idle_ramREN", ramREN, 0);
      check("i_idle_iwait", iwait, 1);
      tick();

      // simultaneous requests: data first, turnaround, then instruction
      iREN = 1; iaddr = 32'h200; dREN = 1; daddr = 32'h100;
      tick();
      #1 check("tie_ramaddr", ramaddr, 32'h100);
      check("tie_iwait", iwait, 1);
      ramstate = 2'd2; ramload = 32'h55;
      #1 check("tie_dwait", dwait, 0);
      check("tie_dload", dload, 32'h55);
      tick(); dREN = 0; ramstate = 2'd0;
      #1 check("tie_turn_ramREN", ramREN, 0);
      tick();
      #1 check("tie_i_ramaddr", ramaddr, 32'h200);
      check("tie_i_ramREN", ramREN, 1);
      ramstate = 2'd2;
      tick(); iREN = 0; ramstate = 2'd0;
      tick();
      iREN = 1; dREN = 1;
      tick();
`ifdef MEM_ARB_RR_EN
      exp_tie2 = 32'h200;
`else
      exp_tie2 = 32'h100;
`endif
      #1 check("tie2_ramaddr", ramaddr, exp_tie2);
      drain();
      tick();

      // write beats read when both enables are set
      dWEN = 1; dREN = 1; dstore = 32'h12345678; daddr = 32'h80;
      tick(); ramstate = 2'd1;
      #1 check("w_ramWEN", ramWEN, 1);
      check("w_ramREN", ramREN, 0);
      check("w_ramstore", ramstore, 32'h12345678);
      check("w_busy_dwait", dwait, 1);
      ramstate = 2'd2;
      #1 check("w_acc_dwait", dwait, 0);
      tick(); dWEN = 0; dREN = 0; ramstate = 2'd0;
      tick();

      // withdrawn data request
      dREN = 1; daddr = 32'h300;
      tick(); ramstate = 2'd1;
      #1 check("wd_ramREN", ramREN, 1);
      dREN = 0;
      #1 check("wd_drop_ramREN", ramREN, 0);
      check("wd_dwait", dwait, 1);
      tick();
      #1 check("wd_idle_ramaddr", ramaddr, 0);
      check("wd_idle_dwait", dwait, 1);
      ramstate = 2'd0;
      tick();

      // ERROR during instruction grant, then retry
      iREN = 1; iaddr = 32'h44;
      tick(); ramstate = 2'd3;
      #1 check("e_iwait", iwait, 1);
      check("e_err_pre", arb_err, 0);
      tick(); ramstate = 2'd1;
      #1 check("e_err_set", arb_err, 1);
      check("e_idle_ramREN", ramREN, 0);
      tick(); ramstate = 2'd2; ramload = 32'hA5A5A5A5;
      #1 check("e_retry_iwait", iwait, 0);
      check("e_retry_iload", iload, 32'hA5A5A5A5);
      tick(); iREN = 0; ramstate = 2'd0;
      #1 check("e_err_sticky", arb_err, 1);
      nRST = 0;
      tick();
      #1 check("e_err_clr", arb_err, 0);
      nRST = 1;
      tick();

      // reset in the middle of a data grant
      dREN = 1; daddr = 32'h500;
      tick(); ramstate = 2'd1;
      #1 check("rd_ramREN", ramREN, 1);
      nRST = 0;
      tick();
      #1 check("rd_ramREN_off", ramREN, 0);
      check("rd_ramaddr", ramaddr, 0);
      check("rd_dwait", dwait, 1);
      check("rd_iwait", iwait, 1);
      nRST = 1; dREN = 0; ramstate = 2'd0;
      tick();

      // randomized traffic
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         idone = iREN && !iwait;
         ddone = (dREN || dWEN) && !dwait;
         @(posedge clk);
         #1;
         if (iREN) begin
            if (idone || $urandom_range(0, 19) == 0) iREN = 0;
         end else if ($urandom_range(0, 2) == 0) begin
            iREN  = 1;
            iaddr = $urandom;
         end
         if (dREN || dWEN) begin
            if (ddone || $urandom_range(0, 19) == 0) begin dREN = 0; dWEN = 0; end
         end else if ($urandom_range(0, 2) == 0) begin
            r = $urandom_range(1, 3);
            dREN   = r[0];
            dWEN   = r[1];
            daddr  = $urandom;
            dstore = $urandom;
         end
         r = $urandom_range(0, 19);
         if (r < 2) ramstate = 2'd0;
         else if (r < 12) ramstate = 2'd1;
         else if (r < 19) ramstate = 2'd2;
         else ramstate = 2'd3;
         ramload = $urandom;
         nRST = ($urandom_range(0, 199) != 0);
      end

      @(posedge clk);
      #1;
      iREN = 0; dREN = 0; dWEN = 0; nRST = 1; ramstate = 2'd0;
      repeat (3) tick();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
